// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : alu_sequencer
// Brief   : Issue-side controller for the 8-bit ALU: 4x8 register file,
//           C/Z/V flags, 3-cycle IDLE/EXEC/WB instruction sequence.
// Revision: 1.0
// ============================================================================
module alu_sequencer (
   input  logic       clk,
   input  logic       rst,
   input  logic       instr_valid,
   output logic       instr_ready,
   input  logic [7:0] instr,
   input  logic [7:0] imm,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [3:0] alu_op,
   output logic       alu_c_in,
   input  logic [7:0] alu_res,
   input  logic       alu_c_out,
   input  logic       alu_zero,
   input  logic       alu_ovf,
   output logic       done,
   output logic       illegal,
   output logic       flag_c,
   output logic       flag_z,
   output logic       flag_v,
   input  logic [1:0] dbg_sel,
   output logic [7:0] dbg_data
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_WB   = 2'd2
   } state_t;

   localparam logic [3:0] c_op_mov      = 4'd8;
   localparam logic [3:0] c_op_nop      = 4'd9;
   localparam logic [3:0] c_op_rsv_lo   = 4'd10;
   localparam logic [3:0] c_op_rsv_hi   = 4'd14;
   localparam logic [3:0] c_op_ldi      = 4'd15;

   state_t      r_state;
   logic [7:0]  r_regs [4];
   logic [3:0]  r_op;
   logic [1:0]  r_rd;
   logic [7:0]  r_imm;
   logic [7:0]  r_a;
   logic [7:0]  r_b;
   logic [7:0]  r_res;
   logic        r_c_stage;
   logic        r_z_stage;
   logic        r_v_stage;
   logic        r_flag_c;
   logic        r_flag_z;
   logic        r_flag_v;
   logic [7:0]  r_alu_a;
   logic [7:0]  r_alu_b;
   logic [3:0]  r_alu_op;
   logic        r_done;
   logic        r_illegal;

   logic        w_accept;
   logic        w_alu_wb;
   logic        w_reserved;

   // Ready is gated by rst directly so it reads 0 for the whole reset window
   // and 1 as soon as rst drops, without waiting for another edge.
   assign instr_ready = (r_state == S_IDLE) && !rst;
   assign w_accept    = instr_valid && instr_ready;
   assign w_alu_wb    = (r_op <= c_op_mov);
   assign w_reserved  = (r_op >= c_op_rsv_lo) && (r_op <= c_op_rsv_hi);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         for (int i = 0; i < 4; i++) begin
            r_regs[i] <= 8'h00;
         end
         r_op      <= c_op_nop;
         r_rd      <= 2'd0;
         r_imm     <= 8'h00;
         r_a       <= 8'h00;
         r_b       <= 8'h00;
         r_res     <= 8'h00;
         r_c_stage <= 1'b0;
         r_z_stage <= 1'b0;
         r_v_stage <= 1'b0;
         r_flag_c  <= 1'b0;
         r_flag_z  <= 1'b0;
         r_flag_v  <= 1'b0;
         r_alu_a   <= 8'h00;
         r_alu_b   <= 8'h00;
         r_alu_op  <= c_op_nop;
         r_done    <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_illegal <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op     <= instr[7:4];
                  r_rd     <= instr[3:2];
                  r_imm    <= imm;
                  r_a      <= r_regs[instr[3:2]];
                  r_b      <= r_regs[instr[1:0]];
                  // ALU ports are registered, so they are loaded here to be
                  // live exactly during the EXEC cycle.
                  r_alu_a  <= r_regs[instr[3:2]];
                  r_alu_b  <= r_regs[instr[1:0]];
                  r_alu_op <= instr[7:4];
                  r_state  <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_res     <= alu_res;
               r_c_stage <= alu_c_out;
               r_z_stage <= alu_zero;
               r_v_stage <= alu_ovf;
               r_alu_a   <= 8'h00;
               r_alu_b   <= 8'h00;
               r_alu_op  <= c_op_nop;
               r_done    <= 1'b1;
               r_illegal <= w_reserved;
               r_state   <= S_WB;
            end
            S_WB: begin
               if (w_alu_wb) begin
                  r_regs[r_rd] <= r_res;
                  r_flag_c     <= r_c_stage;
                  r_flag_z     <= r_z_stage;
                  r_flag_v     <= r_v_stage;
               end else if (r_op == c_op_ldi) begin
                  r_regs[r_rd] <= r_imm;
                  r_flag_z     <= (r_imm == 8'h00);
               end
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign alu_a    = r_alu_a;
   assign alu_b    = r_alu_b;
   assign alu_op   = r_alu_op;
   assign alu_c_in = r_flag_c;
   assign done     = r_done;
   assign illegal  = r_illegal;
   assign flag_c   = r_flag_c;
   assign flag_z   = r_flag_z;
   assign flag_v   = r_flag_v;
   assign dbg_data = r_regs[dbg_sel];

   // Operand copies are kept for the staged A/B values; only the ALU port
   // registers feed logic, so fold them into a no-op reduction.
   logic w_unused;
   assign w_unused = ^{r_a, r_b};

endmodule
`default_nettype wire
